// File: rtl/priority_arbiter_rr_if.sv
// Request/grant bundle between a set of requesters and the registered arbiter.
// The master modport is the arbiter side; slave is the requester/consumer side.
interface priority_arbiter_rr_if #(
    parameter int WIDTH = 32
);
    localparam int WIDTH_LOG = $clog2(WIDTH);

    logic [WIDTH-1:0]     dec_vld;
    logic                 enc_vld;
    logic                 enc_rdy;
    logic [WIDTH_LOG-1:0] enc_idx;
    logic [WIDTH-1:0]     enc_oh;

    modport master (
        input  dec_vld,
        input  enc_rdy,
        output enc_vld,
        output enc_idx,
        output enc_oh
    );

    modport slave (
        output dec_vld,
        output enc_rdy,
        input  enc_vld,
        input  enc_idx,
        input  enc_oh
    );
endinterface

// File: rtl/priority_arbiter_rr.sv
// Registered fixed-priority / round-robin arbiter with a valid/ready grant stage.
// The granted request is excluded from the selection on its accept edge.
module priority_arbiter_rr #(
    parameter int WIDTH          = 32,
    parameter int MODE           = 1,
    parameter int IMPLEMENTATION = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    priority_arbiter_rr_if.master bus
);
    localparam int WIDTH_LOG = $clog2(WIDTH);

    logic                 vld_q;
    logic [WIDTH_LOG-1:0] idx_q;
    logic [WIDTH-1:0]     oh_q;
    logic [WIDTH_LOG-1:0] ptr_q;
    logic [WIDTH_LOG-1:0] ptr_nxt;
    logic [WIDTH_LOG-1:0] start;
    logic [WIDTH_LOG-1:0] sel;
    logic [WIDTH-1:0]     masked;
    logic                 xfr;
    logic                 ld;
    logic                 any;

    assign xfr     = vld_q & bus.enc_rdy;
    assign ld      = ~vld_q | bus.enc_rdy;
    // oh_q is the one-hot of idx_q whenever vld_q is set, so it doubles as the exclusion mask
    assign masked  = bus.dec_vld & ~(xfr ? oh_q : '0);
    assign any     = |masked;
    assign ptr_nxt = xfr ? ((idx_q == WIDTH_LOG'(WIDTH - 1)) ? '0 : idx_q + WIDTH_LOG'(1))
                         : ptr_q;

    generate
        if (MODE == 1) begin : g_rr
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) ptr_q <= '0;
                else        ptr_q <= ptr_nxt;
            end
            assign start = ptr_nxt;
        end else begin : g_fixed
            assign ptr_q = '0;
            assign start = '0;
        end
    endgenerate

    function automatic logic [WIDTH_LOG-1:0] lsb_idx(input logic [WIDTH-1:0] v);
        logic [WIDTH_LOG-1:0] r;
        r = '0;
        for (int i = WIDTH - 1; i >= 0; i--)
            if (v[i]) r = WIDTH_LOG'(i);
        return r;
    endfunction

    generate
        if (IMPLEMENTATION == 0) begin : g_loop
            logic found;
            always_comb begin
                found = 1'b0;
                sel   = '0;
                for (int i = 0; i < WIDTH; i++) begin
                    if (!found && masked[i] && (i >= int'(start))) begin
                        sel   = WIDTH_LOG'(i);
                        found = 1'b1;
                    end
                end
                for (int i = 0; i < WIDTH; i++) begin
                    if (!found && masked[i]) begin
                        sel   = WIDTH_LOG'(i);
                        found = 1'b1;
                    end
                end
            end
        end else if (IMPLEMENTATION == 1) begin : g_mask
            logic [WIDTH-1:0] thermo;
            logic [WIDTH-1:0] upper;
            // bits at or above the start pointer; fall back to the full vector on wrap
            assign thermo = {WIDTH{1'b1}} << start;
            assign upper  = masked & thermo;
            assign sel    = (|upper) ? lsb_idx(upper) : lsb_idx(masked);
        end else begin : g_bad
            $fatal(1, "priority_arbiter_rr: IMPLEMENTATION must be 0 or 1");
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
            idx_q <= '0;
            oh_q  <= '0;
        end else if (ld) begin
            vld_q <= any;
            idx_q <= any ? sel : '0;
            oh_q  <= any ? ({{(WIDTH-1){1'b0}}, 1'b1} << sel) : '0;
        end
    end

    assign bus.enc_vld = vld_q;
    assign bus.enc_idx = idx_q;
    assign bus.enc_oh  = oh_q;
endmodule

// File: tb/tb_priority_arbiter_rr.sv
// Directed vector table plus hand sequences and a random run against a cyclic-search model
// for the registered round-robin / fixed-priority arbiter.
module tb_priority_arbiter_rr;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    priority_arbiter_rr_if #(.WIDTH(4))  if4a ();
    priority_arbiter_rr_if #(.WIDTH(4))  if4b ();
    priority_arbiter_rr_if #(.WIDTH(5))  if5a ();
    priority_arbiter_rr_if #(.WIDTH(5))  if5b ();
    priority_arbiter_rr_if #(.WIDTH(4))  if4f ();
    priority_arbiter_rr_if #(.WIDTH(4))  if4g ();
    priority_arbiter_rr_if #(.WIDTH(2))  if2a ();
    priority_arbiter_rr_if #(.WIDTH(2))  if2b ();
    priority_arbiter_rr_if #(.WIDTH(32)) if32a ();
    priority_arbiter_rr_if #(.WIDTH(32)) if32b ();

    priority_arbiter_rr #(.WIDTH(4),  .MODE(1), .IMPLEMENTATION(0)) u4a  (.clk(clk), .rst_n(rst_n), .bus(if4a));
    priority_arbiter_rr #(.WIDTH(4),  .MODE(1), .IMPLEMENTATION(1)) u4b  (.clk(clk), .rst_n(rst_n), .bus(if4b));
    priority_arbiter_rr #(.WIDTH(5),  .MODE(1), .IMPLEMENTATION(0)) u5a  (.clk(clk), .rst_n(rst_n), .bus(if5a));
    priority_arbiter_rr #(.WIDTH(5),  .MODE(1), .IMPLEMENTATION(1)) u5b  (.clk(clk), .rst_n(rst_n), .bus(if5b));
    priority_arbiter_rr #(.WIDTH(4),  .MODE(0), .IMPLEMENTATION(0)) u4f  (.clk(clk), .rst_n(rst_n), .bus(if4f));
    priority_arbiter_rr #(.WIDTH(4),  .MODE(0), .IMPLEMENTATION(1)) u4g  (.clk(clk), .rst_n(rst_n), .bus(if4g));
    priority_arbiter_rr #(.WIDTH(2),  .MODE(1), .IMPLEMENTATION(0)) u2a  (.clk(clk), .rst_n(rst_n), .bus(if2a));
    priority_arbiter_rr #(.WIDTH(2),  .MODE(1), .IMPLEMENTATION(1)) u2b  (.clk(clk), .rst_n(rst_n), .bus(if2b));
    priority_arbiter_rr #(.WIDTH(32), .MODE(1), .IMPLEMENTATION(0)) u32a (.clk(clk), .rst_n(rst_n), .bus(if32a));
    priority_arbiter_rr #(.WIDTH(32), .MODE(1), .IMPLEMENTATION(1)) u32b (.clk(clk), .rst_n(rst_n), .bus(if32b));

    // grp: 0 = W4 round-robin, 1 = W5 round-robin, 2 = W4 fixed priority
    typedef struct {
        int         grp;
        logic       rst;
        logic [4:0] dec;
        logic       rdy;
        logic       ev;
        logic [4:0] ei;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input int grp, input logic rst, input logic [4:0] dec,
                       input logic rdy, input logic ev, input logic [4:0] ei);
        vec_t v;
        v.grp = grp; v.rst = rst; v.dec = dec; v.rdy = rdy; v.ev = ev; v.ei = ei;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic av, input logic [4:0] ai,
                         input logic [31:0] ao, input logic ev, input logic [4:0] ei);
        logic [31:0] eo;
        eo = ev ? (32'd1 << ei) : 32'd0;
        checks++;
        if (av !== ev || ai !== ei || ao !== eo) begin
            errors++;
            $display("FAIL %s: got vld=%b idx=%0d oh=%h, want vld=%b idx=%0d oh=%h",
                     name, av, ai, ao, ev, ei, eo);
        end
    endtask

    task automatic drive(input int grp, input logic [31:0] dec, input logic rdy);
        if4a.dec_vld = '0; if4b.dec_vld = '0; if5a.dec_vld = '0; if5b.dec_vld = '0;
        if4f.dec_vld = '0; if4g.dec_vld = '0; if2a.dec_vld = '0; if2b.dec_vld = '0;
        if32a.dec_vld = '0; if32b.dec_vld = '0;
        if4a.enc_rdy = 0; if4b.enc_rdy = 0; if5a.enc_rdy = 0; if5b.enc_rdy = 0;
        if4f.enc_rdy = 0; if4g.enc_rdy = 0; if2a.enc_rdy = 0; if2b.enc_rdy = 0;
        if32a.enc_rdy = 0; if32b.enc_rdy = 0;
        case (grp)
            0: begin if4a.dec_vld = dec[3:0]; if4b.dec_vld = dec[3:0]; if4a.enc_rdy = rdy; if4b.enc_rdy = rdy; end
            1: begin if5a.dec_vld = dec[4:0]; if5b.dec_vld = dec[4:0]; if5a.enc_rdy = rdy; if5b.enc_rdy = rdy; end
            2: begin if4f.dec_vld = dec[3:0]; if4g.dec_vld = dec[3:0]; if4f.enc_rdy = rdy; if4g.enc_rdy = rdy; end
            default: ;
        endcase
    endtask

    task automatic check_grp(input int grp, input string name, input logic ev, input logic [4:0] ei);
        case (grp)
            0: begin
                check({name, "_w4_i0"}, if4a.enc_vld, 5'(if4a.enc_idx), 32'(if4a.enc_oh), ev, ei);
                check({name, "_w4_i1"}, if4b.enc_vld, 5'(if4b.enc_idx), 32'(if4b.enc_oh), ev, ei);
            end
            1: begin
                check({name, "_w5_i0"}, if5a.enc_vld, 5'(if5a.enc_idx), 32'(if5a.enc_oh), ev, ei);
                check({name, "_w5_i1"}, if5b.enc_vld, 5'(if5b.enc_idx), 32'(if5b.enc_oh), ev, ei);
            end
            default: begin
                check({name, "_fix_i0"}, if4f.enc_vld, 5'(if4f.enc_idx), 32'(if4f.enc_oh), ev, ei);
                check({name, "_fix_i1"}, if4g.enc_vld, 5'(if4g.enc_idx), 32'(if4g.enc_oh), ev, ei);
            end
        endcase
    endtask

    // reference model for the random run: modulo-based cyclic search, round-robin mode
    logic m_vld[3];
    int   m_idx[3];
    int   m_ptr[3];

    task automatic model_step(input int p, input int w, input logic [31:0] dec, input logic rdy);
        logic [31:0] m;
        logic xfr;
        int start;
        int sel;
        bit found;
        if (m_vld[p] && !rdy) return;
        xfr = m_vld[p] && rdy;
        m = (w == 32) ? dec : (dec & ((32'd1 << w) - 32'd1));
        start = m_ptr[p];
        if (xfr) begin
            m[m_idx[p]] = 1'b0;
            start = (m_idx[p] == w - 1) ? 0 : m_idx[p] + 1;
        end
        m_ptr[p] = start;
        found = 0;
        sel = 0;
        for (int k = 0; k < w; k++) begin
            int j;
            j = (start + k) % w;
            if (!found && m[j]) begin sel = j; found = 1; end
        end
        m_vld[p] = found;
        m_idx[p] = found ? sel : 0;
    endtask

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        drive(0, 32'b1111, 1'b0);

        add(0, 1, 5'b01111, 0, 0, 0);
        add(0, 1, 5'b01111, 0, 0, 0);
        add(0, 0, 5'b01111, 1, 1, 0);
        add(0, 0, 5'b01111, 1, 1, 1);
        add(0, 0, 5'b01111, 1, 1, 2);
        add(0, 0, 5'b01111, 1, 1, 3);
        add(0, 0, 5'b01111, 1, 1, 0);
        add(0, 0, 5'b01111, 1, 1, 1);
        add(0, 0, 5'b00101, 1, 1, 2);
        add(0, 0, 5'b00101, 1, 1, 0);
        add(0, 0, 5'b00101, 1, 1, 2);
        add(0, 0, 5'b00101, 1, 1, 0);
        add(0, 1, 5'b00000, 0, 0, 0);
        add(0, 0, 5'b00110, 0, 1, 1);
        add(0, 0, 5'b00110, 0, 1, 1);
        add(0, 0, 5'b00110, 0, 1, 1);
        add(0, 0, 5'b01000, 0, 1, 1);
        add(0, 0, 5'b01000, 1, 1, 3);
        add(0, 0, 5'b00000, 1, 0, 0);
        add(0, 0, 5'b00000, 1, 0, 0);

        add(1, 1, 5'b00000, 0, 0, 0);
        add(1, 0, 5'b10001, 1, 1, 0);
        add(1, 0, 5'b10001, 1, 1, 4);
        add(1, 0, 5'b10001, 1, 1, 0);
        add(1, 0, 5'b10001, 1, 1, 4);
        add(1, 0, 5'b10000, 1, 0, 0);
        add(1, 0, 5'b10000, 1, 1, 4);
        add(1, 0, 5'b10000, 1, 0, 0);
        add(1, 0, 5'b10000, 1, 1, 4);

        add(2, 1, 5'b00000, 0, 0, 0);
        add(2, 0, 5'b01010, 1, 1, 1);
        add(2, 0, 5'b01010, 1, 1, 3);
        add(2, 0, 5'b01010, 1, 1, 1);
        add(2, 0, 5'b01010, 1, 1, 3);
        add(2, 0, 5'b01110, 1, 1, 1);
        add(2, 0, 5'b01110, 0, 1, 1);
        add(2, 0, 5'b01110, 1, 1, 2);
        add(2, 0, 5'b01110, 0, 1, 2);
        add(2, 0, 5'b01110, 1, 1, 1);
        add(2, 0, 5'b01110, 0, 1, 1);
        add(2, 0, 5'b01110, 1, 1, 2);

        foreach (tbl[i]) begin
            @(negedge clk);
            rst_n = !tbl[i].rst;
            drive(tbl[i].grp, 32'(tbl[i].dec), tbl[i].rdy);
            @(posedge clk);
            #1;
            check_grp(tbl[i].grp, $sformatf("vec%0d", i), tbl[i].ev, tbl[i].ei);
        end

        // async reset mid-hold after the pointer has advanced
        @(negedge clk); rst_n = 0; drive(0, 32'b0, 0);
        @(posedge clk);
        @(negedge clk); rst_n = 1; drive(0, 32'b1111, 1);
        @(posedge clk); #1; check_grp(0, "ar_seq0", 1, 0);
        @(posedge clk); #1; check_grp(0, "ar_seq1", 1, 1);
        @(posedge clk); #1; check_grp(0, "ar_seq2", 1, 2);
        @(negedge clk); drive(0, 32'b1111, 0);
        @(posedge clk); #1; check_grp(0, "ar_hold", 1, 2);
        #1; rst_n = 0;
        #1; check_grp(0, "ar_async_clear", 0, 0);
        @(negedge clk); rst_n = 1; drive(0, 32'b1001, 0);
        @(posedge clk); #1; check_grp(0, "ar_ptr_reset", 1, 0);
        @(negedge clk); drive(0, 32'b1100, 1);
        @(posedge clk); #1; check_grp(0, "ar_after", 1, 2);

        // random run, W2/W5/W32 round-robin, both implementations against the model
        @(negedge clk); rst_n = 0; drive(-1, 32'b0, 0);
        @(posedge clk);
        for (int p = 0; p < 3; p++) begin m_vld[p] = 0; m_idx[p] = 0; m_ptr[p] = 0; end
        for (int c = 0; c < 10000; c++) begin
            logic [31:0] d2, d5, d32;
            logic r2, r5, r32;
            @(negedge clk);
            rst_n = 1;
            d2  = 32'($urandom_range(0, 3));
            d5  = 32'($urandom_range(0, 31));
            d32 = ($urandom_range(0, 7) == 0) ? 32'b0 : ($urandom & $urandom & $urandom);
            r2  = ($urandom_range(0, 3) != 0);
            r5  = ($urandom_range(0, 3) != 0);
            r32 = ($urandom_range(0, 3) != 0);
            if2a.dec_vld = d2[1:0];  if2b.dec_vld = d2[1:0];  if2a.enc_rdy = r2;  if2b.enc_rdy = r2;
            if5a.dec_vld = d5[4:0];  if5b.dec_vld = d5[4:0];  if5a.enc_rdy = r5;  if5b.enc_rdy = r5;
            if32a.dec_vld = d32;     if32b.dec_vld = d32;     if32a.enc_rdy = r32; if32b.enc_rdy = r32;
            model_step(0, 2, d2, r2);
            model_step(1, 5, d5, r5);
            model_step(2, 32, d32, r32);
            @(posedge clk);
            #1;
            check($sformatf("rnd_w2_i0_c%0d", c),  if2a.enc_vld,  5'(if2a.enc_idx),  32'(if2a.enc_oh),  m_vld[0], 5'(m_idx[0]));
            check($sformatf("rnd_w2_i1_c%0d", c),  if2b.enc_vld,  5'(if2b.enc_idx),  32'(if2b.enc_oh),  m_vld[0], 5'(m_idx[0]));
            check($sformatf("rnd_w5_i0_c%0d", c),  if5a.enc_vld,  5'(if5a.enc_idx),  32'(if5a.enc_oh),  m_vld[1], 5'(m_idx[1]));
            check($sformatf("rnd_w5_i1_c%0d", c),  if5b.enc_vld,  5'(if5b.enc_idx),  32'(if5b.enc_oh),  m_vld[1], 5'(m_idx[1]));
            check($sformatf("rnd_w32_i0_c%0d", c), if32a.enc_vld, 5'(if32a.enc_idx), if32a.enc_oh,      m_vld[2], 5'(m_idx[2]));
            check($sformatf("rnd_w32_i1_c%0d", c), if32b.enc_vld, 5'(if32b.enc_idx), if32b.enc_oh,      m_vld[2], 5'(m_idx[2]));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
